// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: sequencing controller for the up/down display counter.
// Handles start/pause/load, programmable inclusive limits [lo,hi], four
// count modes and a one-cycle terminal-count pulse. Runs on div_clk.
//
// state | meaning
// IDLE  | count parked, waiting for a start edge
// RUN   | stepping once per div_clk edge
// HOLD  | paused, count and dir frozen
// DONE  | one-shot finished, count parked at hi
module count_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             div_clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             dir,
  output logic             running,
  output logic             done,
  output logic             tc,
  output logic             cfg_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'b00;
  localparam logic [1:0] MODE_DOWN = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;
  localparam logic [1:0] MODE_ONE  = 2'b11;

  state_t           state, state_nxt;
  logic             start_q;
  logic             start_p;
  logic             eff_dir;
  logic             out_of_range;
  logic [WIDTH-1:0] step_count;
  logic             step_dir;
  logic             step_tc;
  logic             step_done;
  logic [WIDTH-1:0] count_nxt;
  logic             dir_nxt;
  logic             tc_nxt;

  assign start_p      = start & ~start_q;
  assign cfg_err      = (lo > hi);
  assign running      = (state == RUN);
  assign done         = (state == DONE);
  assign out_of_range = (count < lo) || (count > hi);

  // Mode changes only touch dir when a step is actually taken; ping-pong keeps
  // whatever direction it was already travelling.
  always_comb begin
    case (mode)
      MODE_UP, MODE_ONE: eff_dir = 1'b1;
      MODE_DOWN:         eff_dir = 1'b0;
      default:           eff_dir = dir;
    endcase
  end

  // One counting step from the current count under the current mode.
  always_comb begin
    step_count = count;
    step_dir   = eff_dir;
    step_tc    = 1'b0;
    step_done  = 1'b0;
    if (out_of_range) begin
      // Limits moved underneath us: re-enter at the near limit, no tc.
      step_count = eff_dir ? lo : hi;
    end else begin
      case (mode)
        MODE_UP: begin
          if (count == hi) begin
            step_count = lo;
            step_tc    = 1'b1;
          end else begin
            step_count = count + WIDTH'(1);
          end
        end
        MODE_DOWN: begin
          if (count == lo) begin
            step_count = hi;
            step_tc    = 1'b1;
          end else begin
            step_count = count - WIDTH'(1);
          end
        end
        MODE_PING: begin
          if (lo == hi) begin
            step_tc = 1'b1;
          end else if (eff_dir) begin
            if (count == hi) begin
              step_dir   = 1'b0;
              step_count = hi - WIDTH'(1);
              step_tc    = 1'b1;
            end else begin
              step_count = count + WIDTH'(1);
            end
          end else begin
            if (count == lo) begin
              step_dir   = 1'b1;
              step_count = lo + WIDTH'(1);
              step_tc    = 1'b1;
            end else begin
              step_count = count - WIDTH'(1);
            end
          end
        end
        default: begin
          if (count == hi) begin
            step_done = 1'b1;
            step_tc   = 1'b1;
          end else begin
            step_count = count + WIDTH'(1);
          end
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge div_clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state decode: load, then bad limits, then start, then pause.
  always_comb begin
    state_nxt = state;
    if (load || cfg_err) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start_p) state_nxt = RUN;
        RUN: begin
          if (pause)          state_nxt = HOLD;
          else if (step_done) state_nxt = DONE;
        end
        HOLD: if (!pause) state_nxt = RUN;
        default: if (start_p) state_nxt = RUN;
      endcase
    end
  end

  // Output decode: next count, direction and terminal-count pulse.
  always_comb begin
    count_nxt = count;
    dir_nxt   = dir;
    tc_nxt    = 1'b0;
    if (load) begin
      count_nxt = load_val;
      dir_nxt   = (mode != MODE_DOWN);
    end else if (!cfg_err) begin
      case (state)
        IDLE: begin
          if (start_p) begin
            if (mode == MODE_DOWN) begin
              count_nxt = hi;
              dir_nxt   = 1'b0;
            end else begin
              count_nxt = lo;
              dir_nxt   = 1'b1;
            end
          end
        end
        RUN: begin
          if (!pause) begin
            count_nxt = step_count;
            dir_nxt   = step_dir;
            tc_nxt    = step_tc;
          end
        end
        HOLD: ;
        default: begin
          if (start_p) begin
            count_nxt = lo;
            dir_nxt   = 1'b1;
          end
        end
      endcase
    end
  end

  // Registered outputs and the start edge detector.
  always_ff @(posedge div_clk) begin
    if (!rst) begin
      count   <= '0;
      dir     <= 1'b1;
      tc      <= 1'b0;
      start_q <= 1'b0;
    end else begin
      count   <= count_nxt;
      dir     <= dir_nxt;
      tc      <= tc_nxt;
      start_q <= start;
    end
  end

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Directed bench for count_seq_ctrl: each step pushes the expected outputs
// onto a scoreboard queue, clocks once, then pops and compares.
module tb_count_seq_ctrl;

  logic       div_clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic [1:0] mode;
  logic [3:0] lo;
  logic [3:0] hi;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] count;
  logic       dir;
  logic       running;
  logic       done;
  logic       tc;
  logic       cfg_err;

  int ntests = 0;
  int nfail  = 0;

  typedef struct {
    string      tag;
    logic [3:0] count;
    logic [3:0] flags;
  } exp_t;

  exp_t exp_q[$];

  count_seq_ctrl #(.WIDTH(4)) dut (
    .div_clk  (div_clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .mode     (mode),
    .lo       (lo),
    .hi       (hi),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .dir      (dir),
    .running  (running),
    .done     (done),
    .tc       (tc),
    .cfg_err  (cfg_err)
  );

  always #5 div_clk = ~div_clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Push expected {count, dir, running, done, tc}, clock once, pop and compare.
  task automatic tick(input string tag, input logic [3:0] c,
                      input logic d, input logic r, input logic dn, input logic t);
    exp_t e;
    exp_t got;
    e.tag   = tag;
    e.count = c;
    e.flags = {d, r, dn, t};
    exp_q.push_back(e);
    @(posedge div_clk);
    #1;
    got = exp_q.pop_front();
    ntests++;
    assert (count === got.count) else begin
      nfail++;
      $error("FAIL %s count observed=%0d expected=%0d", got.tag, count, got.count);
    end
    ntests++;
    assert ({dir, running, done, tc} === got.flags) else begin
      nfail++;
      $error("FAIL %s dir/run/done/tc observed=%b expected=%b", got.tag,
             {dir, running, done, tc}, got.flags);
    end
  endtask

  task automatic check_cfg(input string tag, input logic e);
    ntests++;
    assert (cfg_err === e) else begin
      nfail++;
      $error("FAIL %s cfg_err observed=%b expected=%b", tag, cfg_err, e);
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b1; start = 1'b1; pause = 1'b0;
    mode = 2'b00; lo = 4'd0; hi = 4'd15; load_val = 4'd9;
    #1;
    // Reset dominates load and start.
    tick("rst0", 4'd0, 1, 0, 0, 0);
    tick("rst1", 4'd0, 1, 0, 0, 0);
    load = 1'b0; start = 1'b0; rst = 1'b1;
    tick("idle", 4'd0, 1, 0, 0, 0);

    // Mode 00 up-wrap 3..6.
    lo = 4'd3; hi = 4'd6; start = 1'b1;
    tick("up_start", 4'd3, 1, 1, 0, 0);
    tick("up_4", 4'd4, 1, 1, 0, 0);
    tick("up_5", 4'd5, 1, 1, 0, 0);
    tick("up_6", 4'd6, 1, 1, 0, 0);
    tick("up_wrap", 4'd3, 1, 1, 0, 1);
    tick("up_after", 4'd4, 1, 1, 0, 0);
    load = 1'b1; load_val = 4'd0; start = 1'b0;
    tick("up_load", 4'd0, 1, 0, 0, 0);
    load = 1'b0;

    // Mode 10 ping-pong 2..4, then collapse limits to 5..5.
    mode = 2'b10; lo = 4'd2; hi = 4'd4; start = 1'b1;
    tick("pp_start", 4'd2, 1, 1, 0, 0);
    tick("pp_3", 4'd3, 1, 1, 0, 0);
    tick("pp_4", 4'd4, 1, 1, 0, 0);
    tick("pp_rev_hi", 4'd3, 0, 1, 0, 1);
    tick("pp_2", 4'd2, 0, 1, 0, 0);
    tick("pp_rev_lo", 4'd3, 1, 1, 0, 1);
    tick("pp_4b", 4'd4, 1, 1, 0, 0);
    lo = 4'd5; hi = 4'd5;
    tick("pp_oor", 4'd5, 1, 1, 0, 0);
    tick("pp_eq1", 4'd5, 1, 1, 0, 1);
    tick("pp_eq2", 4'd5, 1, 1, 0, 1);
    load = 1'b1; load_val = 4'd0; start = 1'b0;
    tick("pp_load", 4'd0, 1, 0, 0, 0);
    load = 1'b0;

    // Mode 11 one-shot 0..2, hold in DONE, restart.
    mode = 2'b11; lo = 4'd0; hi = 4'd2; start = 1'b1;
    tick("os_start", 4'd0, 1, 1, 0, 0);
    tick("os_1", 4'd1, 1, 1, 0, 0);
    tick("os_2", 4'd2, 1, 1, 0, 0);
    tick("os_done", 4'd2, 1, 0, 1, 1);
    tick("os_held", 4'd2, 1, 0, 1, 0);
    start = 1'b0;
    tick("os_rel", 4'd2, 1, 0, 1, 0);
    start = 1'b1;
    tick("os_restart", 4'd0, 1, 1, 0, 0);
    tick("os_r1", 4'd1, 1, 1, 0, 0);
    mode = 2'b01; load = 1'b1; load_val = 4'd5; start = 1'b0;
    tick("os_load", 4'd5, 0, 0, 0, 0);
    load = 1'b0;

    // Mode 01 down with a 3-cycle pause at 5.
    lo = 4'd0; hi = 4'd7; start = 1'b1;
    tick("dn_start", 4'd7, 0, 1, 0, 0);
    tick("dn_6", 4'd6, 0, 1, 0, 0);
    tick("dn_5", 4'd5, 0, 1, 0, 0);
    pause = 1'b1;
    tick("dn_hold1", 4'd5, 0, 0, 0, 0);
    tick("dn_hold2", 4'd5, 0, 0, 0, 0);
    tick("dn_hold3", 4'd5, 0, 0, 0, 0);
    pause = 1'b0;
    tick("dn_resume", 4'd5, 0, 1, 0, 0);
    tick("dn_4", 4'd4, 0, 1, 0, 0);
    load = 1'b1; load_val = 4'd9;
    tick("dn_load9", 4'd9, 0, 0, 0, 0);
    // Load beats a simultaneous start edge, which is then consumed.
    start = 1'b0; load = 1'b0;
    tick("dn_idle", 4'd9, 0, 0, 0, 0);
    start = 1'b1; load = 1'b1; load_val = 4'd3;
    tick("ld_vs_start", 4'd3, 0, 0, 0, 0);
    load = 1'b0;
    tick("no_retrig", 4'd3, 0, 0, 0, 0);
    start = 1'b0; lo = 4'd2; hi = 4'd4;
    tick("dn_rearm", 4'd3, 0, 0, 0, 0);
    start = 1'b1;
    tick("dw_start", 4'd4, 0, 1, 0, 0);
    tick("dw_3", 4'd3, 0, 1, 0, 0);
    tick("dw_2", 4'd2, 0, 1, 0, 0);
    tick("dw_wrap", 4'd4, 0, 1, 0, 1);
    tick("dw_after", 4'd3, 0, 1, 0, 0);

    // Inverted limits abort RUN and block start.
    mode = 2'b00; lo = 4'd7; hi = 4'd3; start = 1'b0;
    #1;
    check_cfg("cfg_set", 1'b1);
    tick("cfg_abort", 4'd3, 0, 0, 0, 0);
    start = 1'b1;
    tick("cfg_nostart", 4'd3, 0, 0, 0, 0);
    start = 1'b0; lo = 4'd3; hi = 4'd10;
    #1;
    check_cfg("cfg_clr", 1'b0);
    tick("cfg_idle", 4'd3, 0, 0, 0, 0);
    start = 1'b1;
    tick("oor_start", 4'd3, 1, 1, 0, 0);
    tick("oor_4", 4'd4, 1, 1, 0, 0);
    tick("oor_5", 4'd5, 1, 1, 0, 0);
    tick("oor_6", 4'd6, 1, 1, 0, 0);
    tick("oor_7", 4'd7, 1, 1, 0, 0);
    tick("oor_8", 4'd8, 1, 1, 0, 0);
    hi = 4'd5;
    tick("oor_reload", 4'd3, 1, 1, 0, 0);
    tick("oor_next", 4'd4, 1, 1, 0, 0);

    // Pause together with start in IDLE: RUN first, then HOLD.
    load = 1'b1; load_val = 4'd0; start = 1'b0;
    tick("ps_load", 4'd0, 1, 0, 0, 0);
    load = 1'b0; pause = 1'b1; start = 1'b1;
    tick("ps_run", 4'd3, 1, 1, 0, 0);
    tick("ps_hold", 4'd3, 1, 0, 0, 0);
    pause = 1'b0;
    tick("ps_resume", 4'd3, 1, 1, 0, 0);
    tick("ps_step", 4'd4, 1, 1, 0, 0);

    // Reset mid-run.
    rst = 1'b0;
    tick("rst_run", 4'd0, 1, 0, 0, 0);
    rst = 1'b1; start = 1'b0;
    tick("rst_idle", 4'd0, 1, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
